// File: rtl/sgde_pkg.sv
// Shared types and width helpers for the second-generation sprite drawing engine.
package sgde_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StDraw,
    StDrain,
    StDone
  } sgde_state_e;

  // List entries are stored at a fixed maximum width; unused high bits stay zero.
  localparam int unsigned CoordMaxW = 16;
  localparam int unsigned TypeMaxW  = 8;

  typedef struct packed {
    logic [CoordMaxW-1:0] x;
    logic [CoordMaxW-1:0] y;
    logic [TypeMaxW-1:0]  spr_type;
  } sgde_entry_t;

  function automatic int unsigned sr_aw(input int unsigned tw, input int unsigned sw);
    return tw + 2 * sw;
  endfunction

  function automatic int unsigned fb_aw(input int unsigned xw, input int unsigned yw);
    return xw + yw;
  endfunction

endpackage

// File: rtl/sgde_gen2_if.sv
// Command, status and memory-bus signals of the sprite engine.
interface sgde_gen2_if #(
  parameter int unsigned XW = 6,
  parameter int unsigned YW = 6,
  parameter int unsigned SW = 3,
  parameter int unsigned TW = 2,
  parameter int unsigned CW = 12
);
  localparam int unsigned SrAw = sgde_pkg::sr_aw(TW, SW);
  localparam int unsigned FbAw = sgde_pkg::fb_aw(XW, YW);

  logic            sprite;
  logic [XW-1:0]   X;
  logic [YW-1:0]   Y;
  logic [TW-1:0]   sprite_type;
  logic            start;
  logic            clear_en;
  logic [CW-1:0]   bg_color;
  logic            ready;
  logic            done;
  logic            overflow;
  logic            SR_CEN;
  logic [SrAw-1:0] SR_A;
  logic [CW:0]     SR_Q;
  logic            FB_CEN;
  logic            FB_WEN;
  logic [FbAw-1:0] FB_A;
  logic [CW-1:0]   FB_D;

  modport master (
    input  sprite, X, Y, sprite_type, start, clear_en, bg_color, SR_Q,
    output ready, done, overflow, SR_CEN, SR_A, FB_CEN, FB_WEN, FB_A, FB_D
  );

  modport slave (
    output sprite, X, Y, sprite_type, start, clear_en, bg_color, SR_Q,
    input  ready, done, overflow, SR_CEN, SR_A, FB_CEN, FB_WEN, FB_A, FB_D
  );

endinterface

// File: rtl/sgde_sprite_list.sv
// Sprite placement list: NMAX-entry register file with append pointer and sticky overflow.
module sgde_sprite_list import sgde_pkg::*; #(
  parameter int unsigned NMAX = 20,
  parameter int unsigned XW   = 6,
  parameter int unsigned YW   = 6,
  parameter int unsigned TW   = 2,
  localparam int unsigned IdxW = (NMAX > 1) ? $clog2(NMAX) : 1,
  localparam int unsigned CntW = $clog2(NMAX + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [XW-1:0]   x_i,
  input  logic [YW-1:0]   y_i,
  input  logic [TW-1:0]   type_i,
  input  logic            ovf_clr_i,
  input  logic            cnt_clr_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output sgde_entry_t     rd_entry_o,
  output logic [CntW-1:0] cnt_o,
  output logic            overflow_o
);

  sgde_entry_t     mem_q [NMAX];
  logic [CntW-1:0] cnt_q;
  logic            ovf_q;
  logic            room;

  assign room       = cnt_q < CntW'(NMAX);
  assign rd_entry_o = mem_q[rd_idx_i];
  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;

  always_ff @(posedge clk) begin
    if (load_i && room) begin
      mem_q[cnt_q[IdxW-1:0]] <= '{x:        CoordMaxW'(x_i),
                                 y:        CoordMaxW'(y_i),
                                 spr_type: TypeMaxW'(type_i)};
    end
  end

  // A start in the same cycle as a dropped load still clears the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (cnt_clr_i) begin
        cnt_q <= '0;
      end else if (load_i && room) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end else if (load_i && !room) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sgde_gen2.sv
// Sprite drawing engine: optional frame clear, then paints listed sprites from SR into FB.
module sgde_gen2 import sgde_pkg::*; #(
  parameter int unsigned XW   = 6,
  parameter int unsigned YW   = 6,
  parameter int unsigned SW   = 3,
  parameter int unsigned TW   = 2,
  parameter int unsigned CW   = 12,
  parameter int unsigned NMAX = 20
) (
  input logic         clk,
  input logic         reset,
  sgde_gen2_if.master bus
);

  localparam int unsigned FbAw = fb_aw(XW, YW);
  localparam int unsigned PixW = 2 * SW;
  localparam int unsigned IdxW = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam int unsigned CntW = $clog2(NMAX + 1);

  sgde_state_e     state_q, state_d;
  logic            alive_q;
  logic [FbAw-1:0] clr_q, clr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic [CW-1:0]   bg_q, bg_d;
  logic            pend_q, pend_d;
  logic [XW:0]     wx_q, wx_d;
  logic [YW:0]     wy_q, wy_d;

  logic            ready;
  logic            load;
  logic            go;
  logic            list_clr;
  logic [CntW-1:0] cnt;
  sgde_entry_t     entry;
  logic [SW-1:0]   pix_r;
  logic [SW-1:0]   pix_c;
  logic            last_pix;
  logic            last_spr;
  logic            wr_pix;
  logic            unused_entry;

  // ready stays low until the first edge after reset release.
  assign ready    = alive_q & (state_q == StIdle);
  assign load     = ready & bus.sprite;
  assign go       = ready & bus.start;
  assign list_clr = (state_q == StDone);
  assign pix_r    = pix_q[PixW-1:SW];
  assign pix_c    = pix_q[SW-1:0];
  assign last_pix = &pix_q;
  assign last_spr = (CntW'(idx_q) + CntW'(1)) == cnt;

  assign bus.ready    = ready;
  assign bus.done     = (state_q == StDone);
  assign unused_entry = ^entry;

  sgde_sprite_list #(
    .NMAX (NMAX),
    .XW   (XW),
    .YW   (YW),
    .TW   (TW)
  ) u_list (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .x_i        (bus.X),
    .y_i        (bus.Y),
    .type_i     (bus.sprite_type),
    .ovf_clr_i  (go),
    .cnt_clr_i  (list_clr),
    .rd_idx_i   (idx_q),
    .rd_entry_o (entry),
    .cnt_o      (cnt),
    .overflow_o (bus.overflow)
  );

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    bg_d    = bg_q;
    pend_d  = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          bg_d  = bus.bg_color;
          clr_d = '0;
          idx_d = '0;
          pix_d = '0;
          // A sprite loaded in the start cycle counts as present.
          if (bus.clear_en) begin
            state_d = StClear;
          end else if (bus.sprite || (cnt != '0)) begin
            state_d = StDraw;
          end else begin
            state_d = StDone;
          end
        end
      end
      StClear: begin
        clr_d = clr_q + FbAw'(1);
        if (&clr_q) begin
          state_d = (cnt != '0) ? StDraw : StDone;
        end
      end
      StDraw: begin
        // Coordinates carry one extra bit so a carry marks the pixel as clipped.
        pend_d = 1'b1;
        wx_d   = {1'b0, entry.x[XW-1:0]} + (XW+1)'(pix_c);
        wy_d   = {1'b0, entry.y[YW-1:0]} + (YW+1)'(pix_r);
        pix_d  = pix_q + PixW'(1);
        if (last_pix) begin
          if (last_spr) begin
            state_d = StDrain;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.SR_CEN = 1'b1;
    bus.SR_A   = '0;
    bus.FB_CEN = 1'b1;
    bus.FB_WEN = 1'b1;
    bus.FB_A   = '0;
    bus.FB_D   = '0;
    wr_pix     = pend_q & bus.SR_Q[CW] & ~wx_q[XW] & ~wy_q[YW];
    if (state_q == StDraw) begin
      bus.SR_CEN = 1'b0;
      bus.SR_A   = {entry.spr_type[TW-1:0], pix_q};
    end
    if (state_q == StClear) begin
      bus.FB_CEN = 1'b0;
      bus.FB_WEN = 1'b0;
      bus.FB_A   = clr_q;
      bus.FB_D   = bg_q;
    end else if (wr_pix) begin
      bus.FB_CEN = 1'b0;
      bus.FB_WEN = 1'b0;
      bus.FB_A   = {wy_q[YW-1:0], wx_q[XW-1:0]};
      bus.FB_D   = bus.SR_Q[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      alive_q <= 1'b0;
      clr_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      bg_q    <= '0;
      pend_q  <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      clr_q   <= clr_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      bg_q    <= bg_d;
      pend_q  <= pend_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
    end
  end

endmodule

// File: tb/tb_sgde_gen2.sv
// Directed bench for sgde_gen2 with behavioural sprite ROM and frame-buffer models.
module tb_sgde_gen2;

  localparam int unsigned XW   = 6;
  localparam int unsigned YW   = 6;
  localparam int unsigned SW   = 3;
  localparam int unsigned TW   = 2;
  localparam int unsigned CW   = 12;
  localparam int unsigned NMAX = 20;
  localparam int unsigned NPIX = 1 << (XW + YW);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [CW-1:0] fb     [NPIX];
  logic [CW-1:0] exp_fb [NPIX];
  int unsigned   n_wr;
  int unsigned   exp_wr;
  int unsigned   first_a;
  int unsigned   last_a;

  sgde_gen2_if #(.XW(XW), .YW(YW), .SW(SW), .TW(TW), .CW(CW)) bus ();

  sgde_gen2 #(
    .XW   (XW),
    .YW   (YW),
    .SW   (SW),
    .TW   (TW),
    .CW   (CW),
    .NMAX (NMAX)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM image: colour = 0x800 + type*0x100 + row*0x10 + col; type 2 is transparent on odd columns.
  function automatic logic [CW:0] rom(input logic [TW+2*SW-1:0] a);
    int t;
    int r;
    int c;
    logic op;
    t  = int'(a[TW+2*SW-1:2*SW]);
    r  = int'(a[2*SW-1:SW]);
    c  = int'(a[SW-1:0]);
    op = !((t == 2) && (c % 2 == 1));
    return {op, 12'(32'h800 + t * 256 + r * 16 + c)};
  endfunction

  always @(posedge clk) begin
    if (bus.SR_CEN === 1'b0) bus.SR_Q <= rom(bus.SR_A);
  end

  always @(posedge clk) begin
    if (bus.FB_CEN === 1'b0 && bus.FB_WEN === 1'b0) begin
      fb[bus.FB_A] = bus.FB_D;
      if (n_wr == 0) first_a = bus.FB_A;
      last_a = bus.FB_A;
      n_wr++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ready"}, bus.ready, 0);
    check_eq({tag, "_done"}, bus.done, 0);
    check_eq({tag, "_ovf"}, bus.overflow, 0);
    check_eq({tag, "_sr_cen"}, bus.SR_CEN, 1);
    check_eq({tag, "_fb_cen"}, bus.FB_CEN, 1);
    check_eq({tag, "_fb_wen"}, bus.FB_WEN, 1);
    check_eq({tag, "_sr_a"}, bus.SR_A, 0);
    check_eq({tag, "_fb_a"}, bus.FB_A, 0);
    check_eq({tag, "_fb_d"}, bus.FB_D, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the load edge.
  task automatic load_sprite(input int x, input int y, input int t);
    bus.X           = x[XW-1:0];
    bus.Y           = y[YW-1:0];
    bus.sprite_type = t[TW-1:0];
    bus.sprite      = 1'b1;
    @(posedge clk);
    #1 bus.sprite = 1'b0;
  endtask

  // Reference painter with clipping and transparency.
  task automatic paint(input int x, input int y, input int t);
    logic [CW:0] px;
    logic [TW+2*SW-1:0] a;
    for (int r = 0; r < (1 << SW); r++) begin
      for (int c = 0; c < (1 << SW); c++) begin
        a  = (TW+2*SW)'((t << (2 * SW)) | (r << SW) | c);
        px = rom(a);
        if (px[CW] && (x + c) < (1 << XW) && (y + r) < (1 << YW)) begin
          exp_fb[(y + r) * (1 << XW) + (x + c)] = px[CW-1:0];
          exp_wr++;
        end
      end
    end
  endtask

  task automatic fill_exp(input logic [CW-1:0] v);
    for (int i = 0; i < NPIX; i++) exp_fb[i] = v;
  endtask

  task automatic check_frame(input string tag);
    int bad = 0;
    for (int i = 0; i < NPIX; i++) if (fb[i] !== exp_fb[i]) bad++;
    check_eq({tag, "_frame_bad_px"}, bad, 0);
  endtask

  // Cycle k is the value seen just before the k-th edge after the one that samples start.
  task automatic run_frame(input bit clr, input logic [CW-1:0] bg, input int exp_done,
                           input int exp_first, input string tag);
    int  first_wr = -1;
    int  done_k   = -1;
    bit  seen     = 1'b0;
    n_wr          = 0;
    bus.start     = 1'b1;
    bus.clear_en  = clr;
    bus.bg_color  = bg;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.clear_en = 1'b0;
    for (int k = 1; k < 8000 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) check_eq({tag, "_ready_low"}, bus.ready, 0);
      if (first_wr < 0 && bus.FB_CEN === 1'b0) first_wr = k;
      if (bus.done === 1'b1) begin
        seen   = 1'b1;
        done_k = k;
      end
      @(posedge clk);
    end
    check_eq({tag, "_done_cycle"}, done_k, exp_done);
    check_eq({tag, "_first_wr_cycle"}, first_wr, exp_first);
    @(negedge clk);
    check_eq({tag, "_ready_after"}, bus.ready, 1);
    check_eq({tag, "_done_pulse"}, bus.done, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.sprite      = 1'b0;
    bus.start       = 1'b0;
    bus.clear_en    = 1'b0;
    bus.bg_color    = '0;
    bus.X           = '0;
    bus.Y           = '0;
    bus.sprite_type = '0;
    bus.SR_Q        = '0;
    n_wr            = 0;
    for (int i = 0; i < NPIX; i++) fb[i] = '0;
    fill_exp('0);

    repeat (3) @(posedge clk);
    #2;
    check_reset("rst");
    @(negedge clk);
    reset = 1'b1;
    #1 check_eq("rst_release_ready", bus.ready, 0);
    @(posedge clk);
    #1 check_eq("first_edge_ready", bus.ready, 1);

    // One opaque sprite at the origin.
    exp_wr = 0;
    load_sprite(0, 0, 1);
    paint(0, 0, 1);
    run_frame(1'b0, '0, 66, 2, "a");
    check_eq("a_writes", n_wr, 64);
    check_eq("a_px_7_7", fb[455], 12'h977);
    check_eq("a_px_right", fb[8], 12'h000);
    check_frame("a");

    // Clear only.
    fill_exp(12'hFFF);
    run_frame(1'b1, 12'hFFF, 4097, 1, "b");
    check_eq("b_writes", n_wr, 4096);
    check_eq("b_first_addr", first_a, 0);
    check_eq("b_last_addr", last_a, 4095);
    check_frame("b");

    // Clear then a sprite clipped at the bottom-right corner.
    fill_exp(12'h123);
    load_sprite(60, 62, 1);
    paint(60, 62, 1);
    run_frame(1'b1, 12'h123, 4162, 1, "c");
    check_eq("c_writes", n_wr, 4096 + 8);
    check_eq("c_px_corner0", fb[62 * 64 + 60], 12'h900);
    check_eq("c_px_corner1", fb[63 * 64 + 63], 12'h913);
    check_eq("c_no_xwrap", fb[62 * 64 + 0], 12'h123);
    check_eq("c_no_ywrap", fb[0 * 64 + 60], 12'h123);
    check_frame("c");

    // Transparent odd columns.
    load_sprite(10, 5, 2);
    paint(10, 5, 2);
    run_frame(1'b0, '0, 66, 2, "d");
    check_eq("d_writes", n_wr, 32);
    check_eq("d_px_even", fb[5 * 64 + 10], 12'hA00);
    check_eq("d_px_odd_kept", fb[5 * 64 + 11], 12'h123);
    check_frame("d");

    // Overlap: the later sprite wins.
    load_sprite(20, 30, 0);
    load_sprite(20, 30, 3);
    paint(20, 30, 0);
    paint(20, 30, 3);
    run_frame(1'b0, '0, 130, 2, "e");
    check_eq("e_writes", n_wr, 128);
    check_eq("e_px_top", fb[30 * 64 + 20], 12'hB00);
    check_frame("e");

    // List overflow: the 21st load is dropped.
    exp_wr = 0;
    for (int i = 0; i < 21; i++) begin
      load_sprite(i * 3, i * 3, i % 2);
      if (i < 20) paint(i * 3, i * 3, i % 2);
      if (i == 19) check_eq("f_ovf_at_20", bus.overflow, 0);
    end
    check_eq("f_ovf_at_21", bus.overflow, 1);
    run_frame(1'b0, '0, 20 * 64 + 2, 2, "f");
    check_eq("f_ovf_cleared", bus.overflow, 0);
    check_eq("f_writes", n_wr, exp_wr);
    check_frame("f");

    // Reset in the middle of drawing.
    load_sprite(0, 0, 3);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("g_busy_before_rst", bus.SR_CEN, 0);
    reset = 1'b0;
    #1 check_reset("g_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check_eq("g_ready_back", bus.ready, 1);
    run_frame(1'b0, '0, 1, -1, "g");
    check_eq("g_writes", n_wr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sgde_gen2.md
# sgde_gen2

Parametrised second-generation sprite graphics drawing engine. It buffers a list of sprite placements (X, Y, type). On `start` it optionally clears the frame buffer to a background colour. It then paints every sprite from the synchronous sprite ROM (SR) into the synchronous frame buffer (FB) in load order, one pixel per cycle. Compared with the first-generation engine it adds generic frame/sprite/colour sizes, per-pixel transparency, edge clipping and list-overflow reporting.

## Interface
- `XW`, 6: frame width is 2^XW pixels.
- `YW`, 6: frame height is 2^YW pixels.
- `SW`, 3: sprites are 2^SW × 2^SW pixels.
- `TW`, 2: sprite type index width (2^TW types in SR).
- `CW`, 12: colour width.
- `NMAX`, 20: sprite list depth.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sprite`  in  1  load strobe for X/Y/type.
- `X`  in  XW  sprite left column.
- `Y`  in  YW  sprite top row.
- `type`  in  TW  sprite image index.
- `start`  in  1  begin drawing.
- `clear_en`  in  1  sampled with `start`; 1 = clear FB first.
- `bg_color`  in  CW  clear colour, sampled with `start`.
- `ready`  out  1  high in IDLE; accepting `sprite`/`start`.
- `done`  out  1  one-cycle pulse when frame complete.
- `overflow`  out  1  sticky; a load arrived with list full.
- `SR_CEN`  out  1  SR chip enable, active-low.
- `SR_A`  out  TW+2·SW  SR address {type,row,col}.
- `SR_Q`  in  CW+1  {opaque, colour}, valid the cycle after the address.
- `FB_CEN`  out  1  FB chip enable, active-low.
- `FB_WEN`  out  1  FB write enable, active-low.
- `FB_A`  out  XW+YW  FB address {y,x}.
- `FB_D`  out  CW  FB write data.

## Operation
- States: IDLE, CLEAR, DRAW, DRAIN, DONE.
- IDLE: `ready`=1. A `sprite` pulse appends {X,Y,type} when count<NMAX. Otherwise the entry is dropped and `overflow` is set.
- `start` in IDLE latches `clear_en`/`bg_color` and clears `overflow`. Next state is CLEAR if `clear_en`=1, else DRAW, else DONE when count=0.
- `sprite` and `start` in the same cycle: the sprite is stored first and is drawn.
- `sprite`/`start` outside IDLE are ignored.
- CLEAR: write `bg_color` to FB addresses 0 .. 2^(XW+YW)−1 ascending, one per cycle. Then go to DRAW, or DONE when count=0.
- DRAW: sprites in load order; per sprite, row-major r,c = 0..2^SW−1. Issue SR_A={type,r,c} each cycle. After the last read, go to DRAIN.
- Write stage, one cycle behind: if `SR_Q[CW]`=1 and (X+c)<2^XW and (Y+r)<2^YW, perform the FB write with FB_A={Y+r,X+c} and FB_D=`SR_Q[CW-1:0]`. Sums use XW+1/YW+1 bits; a carry means clipped, with no write and no wrap.
- Later sprites overwrite earlier ones (painter's order). Transparent pixels leave the FB unchanged.
- DRAIN: final pending write. Then DONE.
- DONE: `done`=1 for one cycle, sprite count reset to 0, return to IDLE.
- Reset asserted at any time: abort immediately, list count 0, state IDLE. No partial-frame guarantee.

## Timing
- Reset values: `ready`=0, `done`=0, `overflow`=0, `SR_CEN`=1, `FB_CEN`=1, `FB_WEN`=1, `SR_A`=0, `FB_A`=0, `FB_D`=0.
- `ready` rises on the first posedge after reset release.
- Let cycle 0 be the edge that samples `start`, C = clear_en ? 2^(XW+YW) : 0, and P = N·2^(2·SW).
- Clear writes occupy cycles 1..C.
- SR reads occupy cycles C+1..C+P.
- FB writes occupy cycles C+2..C+P+1.
- `done` is high in cycle C+P+2, or in cycle C+1 when N=0.
- `ready` is low from cycle 1 through the `done` cycle, and high the cycle after.
- When idle, `FB_CEN`=`FB_WEN`=`SR_CEN`=1.
- Clipped or transparent write slots keep `FB_CEN`=1.

## Structure
- Package `sgde_pkg` holds:
  - the state enum;
  - width helpers for SR_A/FB_A (TW+2·SW, XW+YW);
  - the sprite entry struct {x,y,type}.
- Sub-module `sgde_sprite_list` holds the NMAX-entry register file, write pointer/count, overflow flag, and read port indexed by the draw counter.
- The top level holds the FSM, pixel counters and write-stage pipeline register.

## Test plan
- Defaults, no clear, one sprite (X=0,Y=0,type=1) with all-opaque SR: 64 FB writes at {r,c}. `done` at cycle 66.
- clear_en=1, bg_color=12'hFFF, zero sprites: 4096 writes of 12'hFFF at addresses 0..4095. `done` at cycle 4097.
- Sprite at X=60,Y=62: only c≤3, r≤1 written (8 writes). No write at addresses wrapping to x<8 or y<6.
- SR type 2 with opaque=0 on odd columns: only even-column pixels written. FB keeps its prior value elsewhere.
- Two overlapping sprites (type 0 then type 3, same X,Y): the final FB holds type-3 colours.
- Load 21 sprites with NMAX=20: `overflow`=1 after the 21st, only 20 drawn, `overflow` cleared by `start`. Reset pulse mid-DRAW returns all outputs to reset values.
